// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: request/response and word-memory bus of the load/store unit
interface lsu_ctrl_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i, mem_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o, mem_addr_o, mem_we_o, mem_wdata_o
  );
  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i, mem_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o, mem_addr_o, mem_we_o, mem_wdata_o
  );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit with alignment/range checks and read-modify-write sub-word stores
// Optional LSU_WORD_STORE_BYPASS_EN: aligned word stores skip the READ cycle.
module lsu_ctrl #(
  parameter int unsigned MEM_WORDS = 64
) (
  input logic       clk_i,
  input logic       rst_ni,
  lsu_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t      state_q, state_d;
  logic        we_q, uns_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, old_q, rdata_q;
  logic        bad, byp;
  logic [31:0] sh, load_val, mask, merged;
  assign bad = bus.req_size_i == 2'b11 ||
               (bus.req_size_i == 2'b01 && bus.req_addr_i[0]) ||
               (bus.req_size_i == 2'b10 && bus.req_addr_i[1:0] != 2'b00) ||
               {2'b00, bus.req_addr_i[31:2]} >= MEM_WORDS;
`ifdef LSU_WORD_STORE_BYPASS_EN
  assign byp = bus.req_we_i && bus.req_size_i == 2'b10;
`else
  assign byp = 1'b0;
`endif
  // lane extraction for loads and lane merge for stores
  assign sh       = bus.mem_rdata_i >> {addr_q[1:0], 3'b000};
  assign load_val = size_q == 2'b00 ? {{24{~uns_q & sh[7]}}, sh[7:0]} :
                    size_q == 2'b01 ? {{16{~uns_q & sh[15]}}, sh[15:0]} : bus.mem_rdata_i;
  assign mask     = size_q == 2'b00 ? 32'h0000_00ff << {addr_q[1:0], 3'b000} :
                    size_q == 2'b01 ? 32'h0000_ffff << {addr_q[1], 4'b0000} : 32'hffff_ffff;
  assign merged   = (old_q & ~mask) | ((wdata_q << {addr_q[1:0], 3'b000}) & mask);
  // state register
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state_q <= IDLE;
    else state_q <= state_d;
  // next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.req_valid_i) state_d = bad ? DONE : (byp ? WRITE : READ);
      READ:  state_d = we_q ? WRITE : DONE;
      WRITE: state_d = DONE;
      DONE:  state_d = IDLE;
    endcase
  end
  // request latch, old-word capture and response data; rdata only changes on the way into DONE
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      old_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q == IDLE && bus.req_valid_i) begin
        we_q    <= bus.req_we_i;
        uns_q   <= bus.req_unsigned_i;
        size_q  <= bus.req_size_i;
        addr_q  <= bus.req_addr_i;
        wdata_q <= bus.req_wdata_i;
        err_q   <= bad;
        if (bad) rdata_q <= '0;
      end
      if (state_q == READ) begin
        old_q <= bus.mem_rdata_i;
        if (!we_q) rdata_q <= load_val;
      end
      if (state_q == WRITE) rdata_q <= '0;
    end
  // outputs decoded from the state register
  always_comb begin
    bus.req_ready_o = state_q == IDLE;
    bus.rsp_valid_o = state_q == DONE;
    bus.rsp_err_o   = state_q == DONE && err_q;
    bus.mem_we_o    = state_q == WRITE;
    bus.mem_addr_o  = state_q == READ || state_q == WRITE ? {addr_q[31:2], 2'b00} : 32'h0;
    bus.mem_wdata_o = state_q == WRITE ? merged : 32'h0;
  end
  assign bus.rsp_rdata_o = rdata_q;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: table vectors, corner sequences and randomized checks against a byte-level model
module tb_lsu_ctrl;
`ifdef LSU_WORD_STORE_BYPASS_EN
  localparam int ST_WORD_LAT = 2;
`else
  localparam int ST_WORD_LAT = 3;
`endif
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;
  lsu_ctrl_if bus();
  lsu_ctrl #(.MEM_WORDS(64)) dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;
  assign bus.mem_rdata_i = mem[bus.mem_addr_o[7:2]];
  always @(posedge clk_i)
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (bus.mem_we_o) mem[bus.mem_addr_o[7:2]] <= bus.mem_wdata_o;
  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask
  task automatic preload(input int idx, input logic [31:0] d);
    @(negedge clk_i);
    pl_en = 1'b1; pl_idx = idx[5:0]; pl_data = d;
    @(negedge clk_i);
    pl_en = 1'b0;
    ref_mem[idx] = d;
  endtask
  // byte-level reference: errors from the alignment/range rules, loads and stores lane by lane
  task automatic model(input bit we, input logic [1:0] size, input bit uns, input logic [31:0] addr,
                       input logic [31:0] wdata, output bit e_err, output logic [31:0] e_rd, output int e_lat);
    longint one = 1;
    longint a = longint'(addr);
    longint n = one << size;
    longint off = a % 4;
    longint w, v;
    int idx;
    e_err = size == 2'b11 || a % n != 0 || a / 4 >= 64;
    e_rd = '0;
    e_lat = 1;
    if (!e_err) begin
      idx = int'(a / 4);
      w = longint'(ref_mem[idx]);
      if (!we) begin
        v = (w >> (8 * off)) % (one << (8 * n));
        if (!uns && v >= (one << (8 * n - 1))) v = v - (one << (8 * n));
        e_rd = v[31:0];
        e_lat = 2;
      end else begin
        for (longint i = 0; i < n; i++)
          w = w - (((w >> (8 * (off + i))) % 256) << (8 * (off + i)))
                + (((longint'(wdata) >> (8 * i)) % 256) << (8 * (off + i)));
        ref_mem[idx] = w[31:0];
        e_lat = n == 4 ? ST_WORD_LAT : 3;
      end
    end
  endtask
  task automatic do_req(input bit we, input logic [1:0] size, input bit uns, input logic [31:0] addr,
                        input logic [31:0] wdata, output bit err, output logic [31:0] rdata,
                        output int lat, output int wcnt, output int wcyc);
    int n = 0;
    @(negedge clk_i);
    bus.req_valid_i = 1'b1; bus.req_we_i = we; bus.req_size_i = size;
    bus.req_unsigned_i = uns; bus.req_addr_i = addr; bus.req_wdata_i = wdata;
    while (!bus.req_ready_o && n < 20) begin @(negedge clk_i); n++; end
    if (!bus.req_ready_o) chk("accept_timeout", 32'(bus.req_ready_o), 32'd1);
    @(posedge clk_i);
    #1 bus.req_valid_i = 1'b0;
    lat = 0; wcnt = 0; wcyc = 0;
    do begin
      @(negedge clk_i);
      lat++;
      if (bus.mem_we_o) begin wcnt++; wcyc = lat; end
    end while (!bus.rsp_valid_o && lat < 20);
    err = bus.rsp_err_o;
    rdata = bus.rsp_rdata_o;
  endtask
  typedef struct {
    bit          pl;
    logic [31:0] pl_data;
    bit          we;
    logic [1:0]  size;
    bit          uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          e_err;
    logic [31:0] e_rdata;
    int          e_lat;
    logic [31:0] e_word;
  } vec_t;
  vec_t vec [12];
  initial begin
    bit err, e_err;
    logic [31:0] rd, e_rd, a, d;
    int lat, e_lat, wcnt, wcyc, n;
    bit we, uns;
    logic [1:0] sz;
    bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_size_i = '0;
    bus.req_unsigned_i = 1'b0; bus.req_addr_i = '0; bus.req_wdata_i = '0;
    #1;
    chk("rst_ready", 32'(bus.req_ready_o), 32'd1);
    chk("rst_mem_we", 32'(bus.mem_we_o), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err_o), 32'd0);
    chk("rst_rdata", bus.rsp_rdata_o, 32'h0);
    chk("rst_mem_addr", bus.mem_addr_o, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata_o, 32'h0);
    #20 rst_ni = 1'b1;
    for (int i = 0; i < 64; i++) preload(i, $urandom);
    vec[0]  = '{1, 32'h8070_f0a5, 0, 2'd0, 0, 32'h10, 32'h0, 0, 32'hffff_ffa5, 2, 32'h8070_f0a5};
    vec[1]  = '{0, 32'h0, 0, 2'd0, 1, 32'h11, 32'h0, 0, 32'h0000_00f0, 2, 32'h8070_f0a5};
    vec[2]  = '{0, 32'h0, 0, 2'd1, 0, 32'h12, 32'h0, 0, 32'hffff_8070, 2, 32'h8070_f0a5};
    vec[3]  = '{0, 32'h0, 0, 2'd2, 0, 32'h10, 32'h0, 0, 32'h8070_f0a5, 2, 32'h8070_f0a5};
    vec[4]  = '{0, 32'h0, 0, 2'd1, 1, 32'h12, 32'h0, 0, 32'h0000_8070, 2, 32'h8070_f0a5};
    vec[5]  = '{1, 32'h1122_3344, 1, 2'd0, 0, 32'h13, 32'h0000_00ab, 0, 32'h0, 3, 32'hab22_3344};
    vec[6]  = '{0, 32'h0, 1, 2'd1, 0, 32'h10, 32'h0000_beef, 0, 32'h0, 3, 32'hab22_beef};
    vec[7]  = '{0, 32'h0, 0, 2'd2, 0, 32'h102, 32'h0, 1, 32'h0, 1, 32'hab22_beef};
    vec[8]  = '{0, 32'h0, 1, 2'd2, 0, 32'h100, 32'h1234_5678, 1, 32'h0, 1, 32'hab22_beef};
    vec[9]  = '{0, 32'h0, 0, 2'd1, 0, 32'h11, 32'h0, 1, 32'h0, 1, 32'hab22_beef};
    vec[10] = '{0, 32'h0, 1, 2'd3, 0, 32'h10, 32'h5555_5555, 1, 32'h0, 1, 32'hab22_beef};
    vec[11] = '{1, 32'h0, 1, 2'd2, 0, 32'hfc, 32'hcafe_babe, 0, 32'h0, ST_WORD_LAT, 32'hcafe_babe};
    for (int i = 0; i < 12; i++) begin
      if (vec[i].pl) preload(int'(vec[i].addr[7:2]), vec[i].pl_data);
      model(vec[i].we, vec[i].size, vec[i].uns, vec[i].addr, vec[i].wdata, e_err, e_rd, e_lat);
      do_req(vec[i].we, vec[i].size, vec[i].uns, vec[i].addr, vec[i].wdata, err, rd, lat, wcnt, wcyc);
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(vec[i].e_err));
      chk($sformatf("vec%0d_rdata", i), rd, vec[i].e_rdata);
      chk($sformatf("vec%0d_lat", i), lat, vec[i].e_lat);
      chk($sformatf("vec%0d_wcnt", i), wcnt, (vec[i].we && !vec[i].e_err) ? 1 : 0);
      if (!vec[i].e_err) chk($sformatf("vec%0d_word", i), mem[vec[i].addr[7:2]], vec[i].e_word);
    end
    // back-to-back word stores with valid held high
    @(negedge clk_i);
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_size_i = 2'd2;
    bus.req_unsigned_i = 1'b0; bus.req_addr_i = 32'h20; bus.req_wdata_i = 32'h0000_0001;
    @(posedge clk_i);
    lat = 0; wcyc = 0;
    do begin @(negedge clk_i); lat++; if (bus.mem_we_o && wcyc == 0) wcyc = lat; end
    while (!bus.rsp_valid_o && lat < 20);
    chk("b2b_lat1", lat, ST_WORD_LAT);
    chk("b2b_wcyc1", wcyc, ST_WORD_LAT - 1);
    chk("b2b_ready_in_done", 32'(bus.req_ready_o), 32'd0);
    bus.req_addr_i = 32'h24; bus.req_wdata_i = 32'h0000_0002;
    @(negedge clk_i);
    chk("b2b_ready_idle", 32'(bus.req_ready_o), 32'd1);
    chk("b2b_rsp_idle", 32'(bus.rsp_valid_o), 32'd0);
    @(posedge clk_i);
    #1 bus.req_valid_i = 1'b0;
    lat = 0; wcyc = 0;
    do begin @(negedge clk_i); lat++; if (bus.mem_we_o && wcyc == 0) wcyc = lat; end
    while (!bus.rsp_valid_o && lat < 20);
    chk("b2b_lat2", lat, ST_WORD_LAT);
    chk("b2b_wcyc2", wcyc, ST_WORD_LAT - 1);
    chk("b2b_word8", mem[8], 32'h0000_0001);
    chk("b2b_word9", mem[9], 32'h0000_0002);
    ref_mem[8] = 32'h0000_0001;
    ref_mem[9] = 32'h0000_0002;
    // reset asserted while the write is on the bus
    preload(5, 32'h5566_7788);
    @(negedge clk_i);
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_size_i = 2'd0;
    bus.req_addr_i = 32'h14; bus.req_wdata_i = 32'h0000_0011;
    @(posedge clk_i);
    #1 bus.req_valid_i = 1'b0;
    n = 0;
    while (!bus.mem_we_o && n < 10) begin @(negedge clk_i); n++; end
    chk("rst_wr_we_seen", 32'(bus.mem_we_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("rst_wr_we_drop", 32'(bus.mem_we_o), 32'd0);
    chk("rst_wr_ready", 32'(bus.req_ready_o), 32'd1);
    chk("rst_wr_rsp", 32'(bus.rsp_valid_o), 32'd0);
    chk("rst_wr_addr", bus.mem_addr_o, 32'h0);
    @(posedge clk_i);
    #1 chk("rst_wr_word", mem[5], 32'h5566_7788);
    @(negedge clk_i);
    rst_ni = 1'b1;
    // randomized traffic against the model
    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      sz = $urandom_range(0, 7) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
      a = $urandom_range(0, 9) == 0 ? $urandom : 32'($urandom_range(0, 255));
      d = $urandom;
      model(we, sz, uns, a, d, e_err, e_rd, e_lat);
      do_req(we, sz, uns, a, d, err, rd, lat, wcnt, wcyc);
      chk("rnd_err", 32'(err), 32'(e_err));
      chk("rnd_rdata", rd, e_rd);
      chk("rnd_lat", lat, e_lat);
      chk("rnd_wcnt", wcnt, (we && !e_err) ? 1 : 0);
      if (we && !e_err) begin
        chk("rnd_wcyc", wcyc, e_lat - 1);
        chk("rnd_word", mem[a[7:2]], ref_mem[a[7:2]]);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
